servo_slew_scheduler: RTL

- Sits upstream of the servo bank and drives its `select`/`position`/`in_valid` command interface.
- Holds a per-servo target table written by the host and a per-servo current-position table.
- Once per PWM frame, sweeps all servos and moves each current position toward its target by at most `step`.
- Emits one command per changed servo, so legs move smoothly instead of jumping; host "snap" writes bypass the slew and are sequenced between sweeps.

---
 rtl/servo_pkg.sv | 16 +
 rtl/servo_slew_step.sv | 44 ++++
 rtl/servo_slew_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared constants and state encoding for the servo slew scheduler and servo bank.
package servo_pkg;

    localparam int NUM_SERVOS = 24;
    localparam int SEL_W      = 5;
    localparam int POS_W      = 16;

    // state    | meaning
    // ST_IDLE  | waiting for frame wrap, host writes accepted
    // ST_SWEEP | one channel per cycle slewed toward its target
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/servo_slew_step.sv
// Combinational slew step: moves current toward target by at most step_q.
// Positions are signed two's complement; the difference is formed one bit
// wider so the full -32768..32767 range never overflows.
module servo_slew_step
#(
    parameter int POS_W = servo_pkg::POS_W
) (
    input  logic [POS_W-1:0] i_current,
    input  logic [POS_W-1:0] i_target,
    input  logic [POS_W-1:0] i_step_q,
    output logic [POS_W-1:0] o_next,
    output logic             o_changed
);
    import servo_pkg::*;

    // Plain bit vectors: add/sub are identical for signed and unsigned,
    // only the top bit of the widened difference is read as a sign.
    logic [POS_W:0] w_cur_ext;
    logic [POS_W:0] w_tgt_ext;
    logic [POS_W:0] w_step_ext;
    logic [POS_W:0] w_diff;
    logic [POS_W:0] w_abs;
    logic [POS_W:0] w_moved;
    logic           w_neg;

    assign w_cur_ext  = {i_current[POS_W-1], i_current};
    assign w_tgt_ext  = {i_target[POS_W-1], i_target};
    assign w_step_ext = {1'b0, i_step_q};
    assign w_diff     = w_tgt_ext - w_cur_ext;
    assign w_neg      = w_diff[POS_W];
    assign w_abs      = w_neg ? (~w_diff + 1'b1) : w_diff;
    assign w_moved    = w_neg ? (w_cur_ext - w_step_ext) : (w_cur_ext + w_step_ext);

    // Land exactly on target when within one step, otherwise take a full step.
    // A full step never passes the target, so the narrowed result stays in range.
    always_comb begin
        o_next = i_target;
        if (w_abs > w_step_ext) begin
            o_next = w_moved[POS_W-1:0];
        end
        o_changed = (o_next != i_current);
    end

endmodule

// File: rtl/servo_slew_scheduler.sv
// Per-frame slew scheduler in front of the servo bank. Host writes set the
// per-channel targets; once per frame every channel is stepped toward its
// target and a command is issued for each channel that moved. Snap writes
// jump straight to the target and emit one command the following cycle.
module servo_slew_scheduler
#(
    parameter int NUM_SERVOS   = servo_pkg::NUM_SERVOS,
    parameter int SEL_W        = servo_pkg::SEL_W,
    parameter int POS_W        = servo_pkg::POS_W,
    parameter int FRAME_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [SEL_W-1:0]      i_wr_select,
    input  logic [POS_W-1:0]      i_wr_position,
    input  logic                  i_wr_snap,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    output logic                  o_wr_err,
    input  logic [POS_W-1:0]      i_step,
    output logic [SEL_W-1:0]      o_select,
    output logic [POS_W-1:0]      o_position,
    output logic                  o_out_valid,
    output logic                  o_busy,
    output logic [NUM_SERVOS-1:0] o_at_target
);
    import servo_pkg::*;

    localparam int               CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_SERVOS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_frame_cnt;
    logic [SEL_W-1:0]      r_idx;
    logic [POS_W-1:0]      r_step_q;
    logic [POS_W-1:0]      r_target  [NUM_SERVOS];
    logic [POS_W-1:0]      r_current [NUM_SERVOS];
    logic                  r_out_valid;
    logic [SEL_W-1:0]      r_select;
    logic [POS_W-1:0]      r_position;
    logic                  r_wr_err;
    logic [NUM_SERVOS-1:0] r_at_target;

    logic                  w_wrap;
    logic                  w_wr_accept;
    logic                  w_sel_ok;
    logic                  w_snap_emit;
    logic                  w_sweep_write;
    logic [POS_W-1:0]      w_cur;
    logic [POS_W-1:0]      w_tgt;
    logic [POS_W-1:0]      w_next;
    logic                  w_changed;

    assign w_wrap      = (r_frame_cnt == CNT_LAST);
    assign o_wr_ready  = i_rst && (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_SWEEP);
    assign w_wr_accept = i_wr_valid && o_wr_ready;
    assign w_sel_ok    = (int'(i_wr_select) < NUM_SERVOS);
    assign w_snap_emit = w_wr_accept && w_sel_ok && i_wr_snap;

    // Sweep reads one channel per cycle; r_idx stays below NUM_SERVOS while sweeping.
    assign w_cur = r_current[r_idx];
    assign w_tgt = r_target[r_idx];

    servo_slew_step #(
        .POS_W (POS_W)
    ) u_step (
        .i_current (w_cur),
        .i_target  (w_tgt),
        .i_step_q  (r_step_q),
        .o_next    (w_next),
        .o_changed (w_changed)
    );

    assign w_sweep_write = (r_state == ST_SWEEP) && w_changed;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start a sweep on frame wrap, finish after the last channel.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_wrap) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (r_idx == IDX_LAST) w_state_nxt = ST_IDLE;
        endcase
    end

    // Free-running frame counter, independent of the sweep state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_frame_cnt <= '0;
        end else if (w_wrap) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Channel index and step latch; step is frozen for the whole sweep.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_idx    <= '0;
            r_step_q <= '0;
        end else if (w_wrap) begin
            r_idx    <= '0;
            r_step_q <= i_step;
        end else if (r_state == ST_SWEEP) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Target/current tables. Host writes only land in IDLE and sweep updates
    // only in SWEEP, so the two write paths never collide.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                r_target[i]  <= '0;
                r_current[i] <= '0;
            end
        end else begin
            if (w_wr_accept && w_sel_ok) begin
                r_target[i_wr_select] <= i_wr_position;
                if (i_wr_snap) begin
                    r_current[i_wr_select] <= i_wr_position;
                end
            end
            if (w_sweep_write) begin
                r_current[r_idx] <= w_next;
            end
        end
    end

    // Registered command port and write-error pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_out_valid <= 1'b0;
            r_select    <= '0;
            r_position  <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_wr_err    <= w_wr_accept && !w_sel_ok;
            if (w_snap_emit) begin
                r_out_valid <= 1'b1;
                r_select    <= i_wr_select;
                r_position  <= i_wr_position;
            end else if (w_sweep_write) begin
                r_out_valid <= 1'b1;
                r_select    <= r_idx;
                r_position  <= w_next;
            end
        end
    end

    // Per-channel settled flags, one cycle behind the tables.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_at_target <= '0;
        end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                r_at_target[i] <= (r_current[i] == r_target[i]);
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_select    = r_select;
    assign o_position  = r_position;
    assign o_wr_err    = r_wr_err;
    assign o_at_target = r_at_target;

endmodule
